deserializador: RTL and testbench

Serial-to-parallel receiver that sits directly downstream of the `registro` shift register. It samples the register's `S_OUT` bitstream while the register runs in PUSH mode and assembles `WIDTH` bits into a parallel word. The word is presented on a single-entry output buffer with a VALID/READY handshake. Frames whose completion finds the buffer still occupied are dropped, and the drop is recorded in a sticky overflow flag.

---
 rtl/deserializador_pkg.sv | 12 +
 rtl/deserializador_buffer_salida.sv | 35 +++
 rtl/deserializador.sv | 92 +++++++++
 tb/tb_deserializador.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/deserializador_pkg.sv
// Shared definitions for the registro / deserializador pair: FSM states and bit-order codes.
package deserializador_pkg;

    typedef enum logic {
        DES_IDLE  = 1'b0,
        DES_SHIFT = 1'b1
    } des_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/deserializador_buffer_salida.sv
// Single-entry output register with VALID/READY handshake and sticky overflow on dropped frames.
module buffer_salida #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             overflow
);

    logic free;

    // The slot counts as free when the pending word is being taken on this same edge.
    assign free = !valid || ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else if (load && free) begin
            q     <= data;
            valid <= 1'b1;
        end else if (load) begin
            overflow <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/deserializador.sv
// Serial-to-parallel receiver for the registro S_OUT stream; assembles WIDTH-bit words.
module deserializador
    import deserializador_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic             S_IN,
    input  logic             DIR,
    input  logic             START,
    input  logic             READY,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             BUSY,
    output logic             OVERFLOW
);

    localparam int CW = $clog2(WIDTH);

    des_state_t       state, next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, acc_next;
    logic             dir_q, dir_eff, sample, start_edge, done;

    always_ff @(posedge CLK) begin
        if (RESET) state <= DES_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        sample     = 1'b0;
        start_edge = 1'b0;
        done       = 1'b0;
        dir_eff    = dir_q;
        case (state)
            DES_IDLE: begin
                // The START edge already takes bit 1, so it must use the live DIR.
                dir_eff = DIR;
                if (START && ENB) begin
                    sample     = 1'b1;
                    start_edge = 1'b1;
                    next_state = DES_SHIFT;
                end
            end
            DES_SHIFT: begin
                if (ENB) begin
                    sample = 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        done       = 1'b1;
                        next_state = DES_IDLE;
                    end
                end
            end
            default: next_state = DES_IDLE;
        endcase
        acc_next = (dir_eff == DIR_LEFT) ? {acc[WIDTH-2:0], S_IN} : {S_IN, acc[WIDTH-1:1]};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt   <= '0;
            acc   <= '0;
            dir_q <= DIR_LEFT;
        end else begin
            // Counter restarts at START and lands on 1 because that edge consumed bit 1.
            if (start_edge) begin
                cnt   <= CW'(1);
                dir_q <= DIR;
            end else if (sample) begin
                cnt <= cnt + CW'(1);
            end
            if (sample) acc <= acc_next;
        end
    end

    assign BUSY = (state == DES_SHIFT);

    buffer_salida #(.WIDTH(WIDTH)) u_buffer_salida (
        .clk      (CLK),
        .reset    (RESET),
        .load     (done),
        .data     (acc_next),
        .ready    (READY),
        .q        (Q),
        .valid    (VALID),
        .overflow (OVERFLOW)
    );

endmodule

// File: tb/tb_deserializador.sv
// Scoreboard bench for deserializador: directed scenarios plus randomized frames.
module tb_deserializador;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         ENB = 1'b0;
    logic         S_IN = 1'b0;
    logic         DIR = 1'b0;
    logic         START = 1'b0;
    logic         READY = 1'b0;
    logic [W-1:0] Q;
    logic         VALID, BUSY, OVERFLOW;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] exp_q[$];
    bit           model_full = 1'b0;
    bit           model_ovf = 1'b0;

    deserializador #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENB      (ENB),
        .S_IN     (S_IN),
        .DIR      (DIR),
        .START    (START),
        .READY    (READY),
        .Q        (Q),
        .VALID    (VALID),
        .BUSY     (BUSY),
        .OVERFLOW (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic bit_at(input logic [W-1:0] w, input logic d, input int i);
        return d ? w[i] : w[W-1-i];
    endfunction

    // Monitor: every accepted word must be the oldest word the model expects.
    always @(negedge CLK) begin
        if (!RESET && VALID && READY) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got %h expected none", Q);
            end else begin
                check("accepted_word", Q, exp_q.pop_front());
            end
        end
    end

    // One clock edge: update the buffer model from the inputs about to be sampled, then compare.
    task automatic tick(input bit complete, input logic [W-1:0] w);
        bit hs;
        hs = model_full && READY;
        if (complete) begin
            if (!model_full || READY) begin
                exp_q.push_back(w);
                model_full = 1'b1;
            end else begin
                model_ovf = 1'b1;
            end
        end else if (hs) begin
            model_full = 1'b0;
        end
        @(posedge CLK);
        #1;
        check("valid", VALID, model_full);
        check("overflow", OVERFLOW, model_ovf);
        if (model_full && exp_q.size() > 0) check("q_hold", Q, exp_q[0]);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        START = 1'b0;
        ENB   = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        exp_q.delete();
        model_full = 1'b0;
        model_ovf  = 1'b0;
        check("rst_q", Q, '0);
        check("rst_valid", VALID, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_overflow", OVERFLOW, 1'b0);
    endtask

    task automatic idle(input int n, input bit rnd_ready);
        for (int k = 0; k < n; k++) begin
            START = 1'b0;
            ENB   = 1'($urandom_range(0, 1));
            S_IN  = 1'($urandom_range(0, 1));
            if (rnd_ready) READY = 1'($urandom_range(0, 1));
            tick(1'b0, '0);
            check("idle_busy", BUSY, 1'b0);
        end
    endtask

    // ready_mode: 0 hold READY, 1 random per cycle, 2 low until the last-bit cycle then high.
    task automatic send_frame(input logic [W-1:0] w, input logic d, input int pause_at,
                              input int pause_len, input bit toggle, input bit rnd_enb,
                              input int ready_mode, input int abort_at, output int edges);
        int i;
        int pl;
        bit en;
        i = 0;
        pl = pause_len;
        edges = 0;
        while (i < W) begin
            if (i == abort_at) break;
            if (i == 0) en = 1'b1;
            else if (i == pause_at && pl > 0) begin
                en = 1'b0;
                pl--;
            end else if (rnd_enb) en = ($urandom_range(0, 3) != 0);
            else en = 1'b1;
            ENB   = en;
            START = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (i == 0) DIR = d;
            else if (toggle) DIR = 1'($urandom_range(0, 1));
            S_IN = en ? bit_at(w, d, i) : 1'($urandom_range(0, 1));
            if (ready_mode == 1) READY = 1'($urandom_range(0, 1));
            else if (ready_mode == 2) READY = (en && i == W - 1);
            tick(en && i == W - 1, w);
            edges++;
            if (en) i++;
            check("busy", BUSY, i < W);
        end
        START = 1'b0;
        ENB   = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        do_reset();

        READY = 1'b1;
        send_frame(32'hF09DF09D, 1'b0, -1, 0, 1'b0, 1'b0, 0, -1, e);
        check("msb_latency", e, 32);
        idle(1, 1'b0);

        send_frame(32'h82F9505F, 1'b1, -1, 0, 1'b0, 1'b0, 0, -1, e);
        idle(1, 1'b0);
        send_frame(32'h82F9505F, 1'b1, -1, 0, 1'b1, 1'b0, 0, -1, e);
        idle(1, 1'b0);
        send_frame(32'h3C5A9617, 1'b0, -1, 0, 1'b1, 1'b0, 0, -1, e);
        idle(1, 1'b0);

        send_frame(32'hCAD6F09D, 1'b0, 10, 5, 1'b0, 1'b0, 0, -1, e);
        check("pause_latency", e, 37);
        idle(1, 1'b0);

        START = 1'b1;
        ENB   = 1'b0;
        tick(1'b0, '0);
        check("start_no_enb", BUSY, 1'b0);
        START = 1'b0;

        READY = 1'b0;
        send_frame(32'h0000FFFF, 1'b0, -1, 0, 1'b0, 1'b0, 0, -1, e);
        send_frame(32'h12345678, 1'b1, -1, 0, 1'b0, 1'b0, 0, -1, e);
        check("bp_overflow", OVERFLOW, 1'b1);
        check("bp_q", Q, 32'h0000FFFF);
        idle(3, 1'b0);
        READY = 1'b1;
        idle(2, 1'b0);
        check("bp_overflow_sticky", OVERFLOW, 1'b1);

        do_reset();
        READY = 1'b0;
        send_frame(32'hDEADBEEF, 1'b0, -1, 0, 1'b0, 1'b0, 0, -1, e);
        send_frame(32'h0BADF00D, 1'b1, -1, 0, 1'b0, 1'b0, 2, -1, e);
        check("same_edge_q", Q, 32'h0BADF00D);
        check("same_edge_valid", VALID, 1'b1);
        check("same_edge_ovf", OVERFLOW, 1'b0);
        READY = 1'b1;
        idle(2, 1'b0);

        READY = 1'b0;
        send_frame($urandom, 1'b0, -1, 0, 1'b0, 1'b0, 0, -1, e);
        send_frame($urandom, 1'b1, -1, 0, 1'b0, 1'b0, 0, 20, e);
        check("pre_reset_valid", VALID, 1'b1);
        check("pre_reset_busy", BUSY, 1'b1);
        do_reset();
        READY = 1'b1;
        send_frame(32'hA5A5A5A5, 1'b0, -1, 0, 1'b0, 1'b0, 0, -1, e);
        idle(2, 1'b0);

        for (int k = 0; k < 10; k++) begin
            send_frame($urandom, 1'($urandom_range(0, 1)), $urandom_range(1, W - 1),
                       $urandom_range(0, 4), 1'b1, 1'b1, 1, -1, e);
            idle($urandom_range(0, 3), 1'b1);
        end
        READY = 1'b1;
        idle(3, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
